virtual_pe_pipe: RTL and testbench



---
 rtl/virtual_pe_pipe_if.sv | 26 ++
 rtl/virtual_pe_pipe.sv | 189 ++++++++++++++++++
 tb/tb_virtual_pe_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/virtual_pe_pipe_if.sv
// virtual_pe_pipe_if: handshake bundle between a network node and its virtual PE.
// Input side: NIN joined valid/ready channels, each DW bits wide, packed in in_data.
// Output side: a single valid/ready flit stream.
interface virtual_pe_pipe_if #(
  parameter int DW  = 32,
  parameter int NIN = 2
);
  logic [NIN*DW-1:0] in_data;
  logic [NIN-1:0]    in_valid;
  logic [NIN-1:0]    in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;

  // Network side: drives the input streams and accepts the output stream.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // PE side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/virtual_pe_pipe.sv
// virtual_pe_pipe: dependency-only PE model. Joins NIN input streams, delays each
// joined token (XOR of the input words) by LAT cycles and drains it through a
// credit-protected output FIFO. Credits are reserved at the join, so the FIFO can
// never overflow and the compute pipeline never has to stall.
// Optional build macro VPE_PERF_EN: enables stall/backpressure counters and the
// start/finish trace lines; without it stall_cnt and bp_cnt are tied to 0.
module virtual_pe_pipe #(
  parameter int DW    = 32,
  parameter int NIN   = 2,
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int NPKT  = 10000,
  parameter int X     = 0,
  parameter int Y     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  virtual_pe_pipe_if.slave     bus,
  output logic [31:0]          in_cnt,
  output logic [31:0]          out_cnt,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bp_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int STG = (LAT > 1) ? LAT - 1 : 1;

  // Catch impossible configurations at elaboration time.
  generate
    if (NIN < 1 || NIN > 4 || LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        X < 0 || Y < 0) begin : g_bad_cfg
      $error("virtual_pe_pipe: unsupported parameter set");
    end
  endgenerate

  // ---------------------------------------------------------------- join
  logic [CW-1:0] credit_q, credit_d;
  logic          all_valid, has_credit, join_fire, out_fire;
  logic [DW-1:0] token;

  assign all_valid  = &bus.in_valid;
  assign has_credit = (credit_q != '0);
  // Reset gates the join so nothing is accepted while state is being flushed.
  assign join_fire  = all_valid & has_credit & ~rst;
  assign bus.in_ready = {NIN{join_fire}};

  // Token tag: XOR of all joined input words.
  always_comb begin
    token = '0;
    for (int i = 0; i < NIN; i++) token = token ^ bus.in_data[i*DW +: DW];
  end

  // ---------------------------------------------------------------- compute pipeline
  logic          wr_en;
  logic [DW-1:0] wr_data;

  generate
    if (LAT == 1) begin : g_nopipe
      assign wr_en   = join_fire;
      assign wr_data = token;
    end else begin : g_pipe
      logic [STG-1:0] vld_q;
      logic [DW-1:0]  data_q [STG];

      // Free-running shift register: a token advances one stage every cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q <= {vld_q[STG-2:0], join_fire};
        end
        data_q[0] <= token;
        for (int s = 1; s < STG; s++) data_q[s] <= data_q[s-1];
      end

      assign wr_en   = vld_q[STG-1];
      assign wr_data = data_q[STG-1];
    end
  endgenerate

  // ---------------------------------------------------------------- output FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic          fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign out_fire      = fifo_nonempty & bus.out_ready;
  assign bus.out_valid = fifo_nonempty;
  assign bus.out_data  = head_q;

  // Pointer/occupancy update; the head register is reloaded from the next read
  // address, bypassing the write when that address is being written this cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(out_fire);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    count_d  = count_q + CW'(wr_en) - CW'(out_fire);
    head_d   = mem[rd_ptr_d];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
  end

  // FIFO storage: write port only, contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  // FIFO control and registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // ---------------------------------------------------------------- credit and status
  logic [31:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic        done_q, done_d, done_rise;

  assign done_rise = out_fire && (out_cnt_q == 32'(NPKT - 1));

  // Credit: reserved at the join, returned when the flit leaves the FIFO.
  always_comb begin
    credit_d  = credit_q - CW'(join_fire) + CW'(out_fire);
    in_cnt_d  = in_cnt_q + 32'(join_fire);
    out_cnt_d = out_cnt_q + 32'(out_fire);
    done_d    = done_q | done_rise;
  end

  // Credit, token counters and sticky done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q  <= CW'(DEPTH);
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
    end
  end

  assign in_cnt  = in_cnt_q;
  assign out_cnt = out_cnt_q;
  assign done    = done_q;
  assign busy    = (credit_q != CW'(DEPTH));

  // ---------------------------------------------------------------- performance counters
`ifdef VPE_PERF_EN
  logic [31:0] stall_q, bp_q;
  logic        started_q;

  // Stall: join blocked only by missing credit; backpressure: output held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      bp_q      <= '0;
      started_q <= 1'b0;
    end else begin
      if (all_valid && !has_credit) stall_q <= stall_q + 32'd1;
      if (fifo_nonempty && !bus.out_ready) bp_q <= bp_q + 32'd1;
      if (join_fire && !started_q) begin
        started_q <= 1'b1;
        $display("node (%0d, %0d) starting computing", X, Y);
      end
      if (done_rise && !done_q) $display("node (%0d, %0d) finished computing", X, Y);
    end
  end

  assign stall_cnt = stall_q;
  assign bp_cnt    = bp_q;
`else
  assign stall_cnt = '0;
  assign bp_cnt    = '0;
`endif

endmodule

// File: tb/tb_virtual_pe_pipe.sv
// tb_virtual_pe_pipe: directed bench for virtual_pe_pipe (NIN=2, LAT=4, DEPTH=8,
// NPKT=16). Joins are observed on the input side and their XOR tag pushed into a
// scoreboard queue; an output monitor pops and compares on every output fire.
module tb_virtual_pe_pipe;
  localparam int DW = 32, NIN = 2, LAT = 4, DEPTH = 8, NPKT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  virtual_pe_pipe_if #(.DW(DW), .NIN(NIN)) bus ();
  logic [31:0] in_cnt, out_cnt, stall_cnt, bp_cnt;
  logic        busy, done;

  virtual_pe_pipe #(.DW(DW), .NIN(NIN), .LAT(LAT), .DEPTH(DEPTH), .NPKT(NPKT), .X(1), .Y(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .in_cnt(in_cnt), .out_cnt(out_cnt), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .bp_cnt(bp_cnt)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xor_in(input logic [NIN*DW-1:0] d);
    logic [31:0] x = '0;
    for (int i = 0; i < NIN; i++) x = x ^ d[i*DW +: DW];
    return x;
  endfunction

  // Input-side monitor: every observed join pushes its expected tag.
  always @(negedge clk) begin
    if (!rst && (&bus.in_valid) && bus.in_ready[0]) exp_q.push_back(xor_in(bus.in_data));
  end

  // Output-side monitor: scoreboard compare, done flag and hold stability.
  logic        hold_q = 1'b0;
  logic [31:0] hold_data = '0;
  always @(negedge clk) begin
    if (hold_q && !rst) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", bus.out_data, hold_data);
    end
    hold_q    = !rst && bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("done_vs_pops", 32'(done), 32'(pop_cnt >= NPKT));
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL out_unexpected: got 0x%08h, expected no output", bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q.pop_front());
      end
      pop_cnt++;
    end
  end

  // Hard stop if the bench itself ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One token; returns cycles from join to out_valid.
  task automatic send_one(input logic [31:0] a0, input logic [31:0] a1, output int lat);
    @(posedge clk); #1;
    bus.in_data = {a1, a0}; bus.in_valid = '1;
    @(negedge clk);
    check("send_fire", 32'(bus.in_ready), 32'h3);
    @(posedge clk); #1;
    bus.in_valid = '0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while ((busy || bus.out_valid) && n < 100);
    check(name, 32'(busy), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int not_ready;
    rst = 1'b1;
    bus.in_data = '0; bus.in_valid = 2'b11; bus.out_ready = 1'b1;

    // Reset state, with all inputs valid.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_cnt", in_cnt, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = '0;
    repeat (4) @(posedge clk);

    // Single token: 0xF0 ^ 0x0F = 0xFF, latency LAT.
    send_one(32'h0000_000F, 32'h0000_00F0, lat);
    check("single_lat", 32'(lat), 32'(LAT));
    check("single_data", bus.out_data, 32'h0000_00FF);
    repeat (2) @(negedge clk);
    check("single_in_cnt", in_cnt, 32'd1);
    check("single_out_cnt", out_cnt, 32'd1);

    // Join hold-off: only channel 0 valid for 20 cycles.
    @(posedge clk); #1;
    bus.in_data = {32'h1234_0000, 32'h0000_5678}; bus.in_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("holdoff_ready", 32'(bus.in_ready), 32'd0);
      if (i < 19) @(posedge clk);
    end
    @(posedge clk); #1;
    bus.in_valid = 2'b11;
    @(negedge clk);
    check("holdoff_fire", 32'(bus.in_ready), 32'h3);
    @(posedge clk); #1;
    bus.in_valid = '0;
    wait_idle("holdoff_idle");
    check("holdoff_in_cnt", in_cnt, 32'd2);

    // Credit exhaustion: out_ready low, inputs valid for 20 cycles.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      bus.in_data = {32'(k) * 32'h1111_1111, 32'hA5A5_0000 + 32'(k)}; bus.in_valid = 2'b11;
    end
    @(negedge clk);
    check("exh_in_cnt", in_cnt, 32'd10);
    check("exh_in_ready", 32'(bus.in_ready), 32'd0);
    check("exh_busy", 32'(busy), 32'd1);
`ifdef VPE_PERF_EN
    check("exh_stall_cnt", stall_cnt, 32'd11);
    check("exh_bp_cnt", bp_cnt, 32'd15);
`else
    check("exh_stall_cnt", stall_cnt, 32'd0);
    check("exh_bp_cnt", bp_cnt, 32'd0);
`endif
    // Release: one pop-only cycle, then one join per cycle.
    for (int k = 20; k < 40; k++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_data = {32'(k) * 32'h1111_1111, 32'hA5A5_0000 + 32'(k)};
    end
    @(posedge clk); #1;
    bus.in_valid = '0;
    wait_idle("exh_idle");
    check("exh_rel_in_cnt", in_cnt, 32'd29);
    check("exh_rel_out_cnt", out_cnt, 32'd29);

    // Throughput: 1000 back-to-back tokens.
    not_ready = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      bus.in_data = {32'(i) * 32'h0101_0101, ~32'(i)}; bus.in_valid = 2'b11;
      @(negedge clk);
      if (!bus.in_ready[0]) not_ready++;
    end
    @(posedge clk); #1;
    bus.in_valid = '0;
    check("tput_not_ready", 32'(not_ready), 32'd0);
    repeat (4) @(negedge clk);
    check("tput_out_cnt_m1", out_cnt, 32'd1028);
    @(negedge clk);
    check("tput_out_cnt", out_cnt, 32'd1029);
    wait_idle("tput_idle");

    // Mid-operation reset with 5 tokens in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_data = {32'hC0DE_0000 + 32'(i), 32'h0000_BEEF}; bus.in_valid = 2'b11;
    end
    @(posedge clk); #1;
    bus.in_valid = '0; rst = 1'b1;
    exp_q.delete(); pop_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_out_data", bus.out_data, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_in_cnt", in_cnt, 32'd0);
    check("mrst_out_cnt", out_cnt, 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_stall", stall_cnt, 32'd0);
    check("mrst_bp", bp_cnt, 32'd0);
    bus.out_ready = 1'b1;
    send_one(32'h8000_0001, 32'h0000_0003, lat);
    check("mrst_lat", 32'(lat), 32'(LAT));
    check("mrst_data", bus.out_data, 32'h8000_0002);
    wait_idle("mrst_idle");
    check("done_before", 32'(done), 32'd0);

    // Done: 25 more tokens, done rises on the 16th output and stays.
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      bus.in_data = {32'(i) << 8, 32'h5A00_0000 | 32'(i)}; bus.in_valid = 2'b11;
    end
    @(posedge clk); #1;
    bus.in_valid = '0;
    wait_idle("done_idle");
    check("done_out_cnt", out_cnt, 32'd26);
    check("done_in_cnt", in_cnt, 32'd26);
    check("done_final", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
